// File: rtl/apuf_eval_ctrl.sv
// Arbiter-PUF evaluation controller: holds the challenge, fires the trigger NREP
// times with settle gaps, and majority-votes the sampled responses.
module apuf_eval_ctrl #(
  parameter int NCHAL   = 128,
  parameter int NREP    = 5,
  parameter int SETTLE  = 16,
  parameter int TIMEOUT = 1024,
  localparam int NWORDS = NCHAL / 64,
  localparam int WID    = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             chal_en,
  input  logic             wr_en,
  input  logic [WID-1:0]   word_id,
  input  logic [63:0]      data_in,
  input  logic             start,
  output logic [NCHAL-1:0] cT,
  output logic             tig,
  input  logic             resp_ready,
  input  logic             resp_bit,
  output logic             busy,
  output logic             done,
  output logic             resp_major,
  output logic [3:0]       ones_cnt,
  output logic             timeout_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ARM, FIRE, GAP, FIN} state_t;

  state_t           state, nextState;
  logic [7:0]       settleCnt;
  logic [TW-1:0]    waitCnt;
  logic [3:0]       repCnt;
  logic [3:0]       onesAcc;
  logic [NCHAL-1:0] chal;
  logic             settleDone;
  logic             timeoutHit;

  function automatic logic majority(input logic [3:0] ones);
    return int'(ones) > (NREP / 2);
  endfunction

  always_comb begin
    nextState  = state;
    settleDone = (settleCnt == 8'(SETTLE - 1));
    timeoutHit = !resp_ready && (waitCnt == TW'(TIMEOUT - 1));
    case (state)
      IDLE: if (start && chal_en) nextState = ARM;
      ARM:  if (settleDone) nextState = FIRE;
      FIRE: begin
        if (resp_ready)      nextState = GAP;
        else if (timeoutHit) nextState = FIN;
      end
      GAP:  if (settleDone) nextState = (repCnt < 4'(NREP)) ? ARM : FIN;
      FIN:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
    // Dropping chal_en mid-vote abandons the vote silently.
    if (!chal_en && state != IDLE) nextState = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      settleCnt   <= '0;
      waitCnt     <= '0;
      repCnt      <= '0;
      onesAcc     <= '0;
      chal        <= '0;
      resp_major  <= 1'b0;
      ones_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= nextState;

      if ((state == ARM || state == GAP) && nextState == state) settleCnt <= settleCnt + 8'd1;
      else                                                      settleCnt <= '0;

      if (state == FIRE && nextState == FIRE) waitCnt <= waitCnt + TW'(1);
      else                                    waitCnt <= '0;

      if (state == IDLE && nextState == ARM) begin
        repCnt      <= '0;
        onesAcc     <= '0;
        timeout_err <= 1'b0;
      end

      if (state == FIRE && nextState == GAP) begin
        repCnt  <= repCnt + 4'd1;
        onesAcc <= onesAcc + 4'(resp_bit);
      end

      // Results are registered on entry to FIN so they are valid while done is high.
      if (nextState == FIN) begin
        ones_cnt    <= onesAcc;
        resp_major  <= majority(onesAcc);
        timeout_err <= (state == FIRE);
      end

      // The challenge only changes in IDLE, so it is stable for a whole vote.
      if (!chal_en) begin
        chal <= '0;
      end else if (wr_en && state == IDLE) begin
        for (int k = 0; k < NWORDS; k++)
          if (word_id == WID'(k)) chal[64*k +: 64] <= data_in;
      end
    end
  end

  assign cT   = chal;
  assign tig  = (state == FIRE);
  assign busy = (state != IDLE);
  assign done = (state == FIN);

endmodule

// File: doc/apuf_eval_ctrl.md
APUF_EVAL_CTRL -- requirements
Module: apuf_eval_ctrl

Interface
REQ-001 SHALL have parameter NCHAL, default 128, meaning challenge width; legal values are multiples of 64 from 64 to 512.
REQ-002 SHALL have parameter NREP, default 5, meaning evaluations per majority vote; legal values are odd, 1..15.
REQ-003 SHALL have parameter SETTLE, default 16, meaning cycles the trigger is held low before each firing; legal values are 1..255.
REQ-004 SHALL have parameter TIMEOUT, default 1024, meaning the maximum cycles to wait for resp_ready per evaluation.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port chal_en, input, 1 bit: 0 clears the challenge register.
REQ-008 SHALL have port wr_en, input, 1 bit: write data_in into the 64-bit slice selected by word_id.
REQ-009 SHALL have port word_id, input, WID = max(1, clog2(NCHAL/64)) bits: slice index; slice k = challenge[64k+63:64k].
REQ-010 SHALL have port data_in, input, 64 bits: challenge slice data.
REQ-011 SHALL have port start, input, 1 bit: request one voted evaluation.
REQ-012 SHALL have port cT, output, NCHAL bits: challenge to the PUF core.
REQ-013 SHALL have port tig, output, 1 bit: trigger to the PUF core.
REQ-014 SHALL have port resp_ready, input, 1 bit: PUF core response valid.
REQ-015 SHALL have port resp_bit, input, 1 bit: PUF core response.
REQ-016 SHALL have port busy, output, 1 bit: high in any non-IDLE state.
REQ-017 SHALL have port done, output, 1 bit: one-cycle pulse when results update.
REQ-018 SHALL have port resp_major, output, 1 bit: majority-voted response.
REQ-019 SHALL have port ones_cnt, output, 4 bits: count of 1 responses in the last vote.
REQ-020 SHALL have port timeout_err, output, 1 bit: the last vote aborted on timeout.

Function
REQ-021 Challenge register SHALL clear to 0 in the cycle after any cycle with chal_en=0.
REQ-022 With chal_en=1 and wr_en=1 in IDLE, the selected slice SHALL load data_in on the next edge; other slices hold.
REQ-023 word_id >= NCHAL/64 SHALL be ignored.
REQ-024 wr_en while busy SHALL be ignored, so cT is stable for a whole vote.
REQ-025 The FSM SHALL have states IDLE, ARM, FIRE, GAP and FIN.
REQ-026 IDLE SHALL go to ARM on start=1 && chal_en=1, clearing the repetition counter, ones counter and timeout_err; start in any other state is ignored.
REQ-027 ARM SHALL hold tig=0 for exactly SETTLE cycles, then go to FIRE.
REQ-028 FIRE SHALL drive tig=1 and sample resp_bit in the first cycle resp_ready=1, incrementing ones if resp_bit=1 and the repetition counter always, then go to GAP.
REQ-029 FIRE SHALL go to FIN with timeout_err=1 when resp_ready has been 0 for TIMEOUT consecutive FIRE cycles.
REQ-030 GAP SHALL hold tig=0 for SETTLE cycles, then go to ARM if repetitions < NREP, else to FIN.
REQ-031 FIN SHALL last one cycle, pulse done=1, latch ones_cnt, set resp_major = (ones > NREP/2), then go to IDLE.
REQ-032 On timeout, resp_major and ones_cnt SHALL reflect only the evaluations completed before the abort.
REQ-033 tig SHALL be 1 only in FIRE, so trigger-to-response latency is measured from the tig rising edge.
REQ-034 chal_en=0 while busy SHALL abort to IDLE on the next edge, with no done pulse and outputs unchanged.
REQ-035 Latency from start to done SHALL be 1 + NREP*(2*SETTLE + Tresp) cycles, where Tresp is the number of FIRE cycles.

Reset
REQ-036 While rst=1, the FSM SHALL be in IDLE and challenge, tig, busy, done, resp_major, ones_cnt, timeout_err and all counters SHALL be 0.
REQ-037 rst SHALL take priority over every other input, including mid-vote.

Verification
REQ-038 Bench SHALL cover: NCHAL=256, write slices 0..3 with 64'h1111..., 64'h2222..., 64'h3333..., 64'h4444... -> cT = {4444...,3333...,2222...,1111...}; word_id=4 -> no change.
REQ-039 Bench SHALL cover: NREP=5, SETTLE=16, core responds 1,0,1,1,0 with resp_ready 3 cycles after tig rises -> done after 1+5*35 = 176 cycles, ones_cnt=3, resp_major=1.
REQ-040 Bench SHALL cover: resp_ready never asserted, TIMEOUT=1024 -> done after 1+16+1024 cycles, timeout_err=1, ones_cnt=0.
REQ-041 Bench SHALL cover: chal_en dropped in GAP of evaluation 2 -> busy=0 next cycle, no done, cT=0.
REQ-042 Bench SHALL cover: rst during FIRE -> tig=0 and all outputs 0 next cycle; start then runs a full vote normally.
REQ-043 Bench SHALL cover: wr_en pulsed during FIRE -> cT unchanged through done.
